// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester data-memory port arbiter with two-cycle bus sequencing
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D-side priority with a starvation guard.
module mem_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN/8-1:0] d_byteen,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN/8-1:0] i_byteen,
    input  logic              i_we,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_err,
    output logic              busy,
    output logic              owner,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byteen,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              own_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN/8-1:0] byteen_q;
    logic              we_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    logic              any_req;
    logic              grant_i;

    assign any_req = d_req | i_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not own the last transaction goes next.
    always_comb begin
        grant_i = i_req;
        if (d_req && i_req) begin
            grant_i = ~own_q;
        end
    end
`else
    logic [3:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = (starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        grant_i = i_req;
        if (d_req && i_req) begin
            grant_i = starve_hit;
        end
    end

    // Counts D-side wins that left a waiting I-side behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (!i_req || grant_i) begin
                starve_cnt <= 4'd0;
            end else if (d_req && starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            own_q    <= 1'b0;
            addr_q   <= '0;
            byteen_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                own_q    <= grant_i;
                addr_q   <= grant_i ? i_addr   : d_addr;
                byteen_q <= grant_i ? i_byteen : d_byteen;
                we_q     <= grant_i ? i_we     : d_we;
                wdata_q  <= grant_i ? i_wdata  : d_wdata;
            end
            if (state == DATA) begin
                rdata_q <= we_q ? '0 : mem_rdata;
                err_q   <= mem_err;
            end
        end
    end

    always_comb begin
        state_next = state;
        d_gnt      = 1'b0;
        i_gnt      = 1'b0;
        d_rvalid   = 1'b0;
        i_rvalid   = 1'b0;
        d_rdata    = '0;
        i_rdata    = '0;
        d_err      = 1'b0;
        i_err      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_byteen = '0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_req    = 1'b1;
                mem_we     = we_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                mem_byteen = byteen_q;
                d_gnt      = ~own_q;
                i_gnt      = own_q;
                state_next = DATA;
            end
            DATA: begin
                mem_req    = 1'b1;
                mem_we     = we_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                mem_byteen = byteen_q;
                state_next = RESP;
            end
            RESP: begin
                if (own_q) begin
                    i_rvalid = 1'b1;
                    i_rdata  = rdata_q;
                    i_err    = err_q;
                end else begin
                    d_rvalid = 1'b1;
                    d_rdata  = rdata_q;
                    d_err    = err_q;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state != IDLE);
    assign owner = own_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter against a transaction-phase model
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_req = 1'b0, i_req = 1'b0;
    logic [31:0] d_addr = '0, i_addr = '0, d_wdata = '0, i_wdata = '0;
    logic [3:0]  d_byteen = '0, i_byteen = '0;
    logic        d_we = 1'b0, i_we = 1'b0;
    logic        d_gnt, i_gnt, d_rvalid, i_rvalid, d_err, i_err, busy, owner;
    logic [31:0] d_rdata, i_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    mem_port_arbiter #(.XLEN(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_addr(d_addr), .d_byteen(d_byteen), .d_we(d_we), .d_wdata(d_wdata),
        .i_req(i_req), .i_addr(i_addr), .i_byteen(i_byteen), .i_we(i_we), .i_wdata(i_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .busy(busy), .owner(owner),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: phase counts cycles into a transaction (0 idle, 1 grant, 2 data, 3 response).
    int          m_phase = 0;
    bit          m_own = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_be = '0;
    bit          m_we = 1'b0, m_err = 1'b0;
    int          m_streak = 0;
    bit          m_rv_d = 1'b0, m_rv_i = 1'b0;

    int  mode = 0;
    bit  rand_mem = 1'b0;
    bit  gnt_log[$];

    logic        o_d_gnt, o_d_rvalid, o_i_rvalid, o_d_err, o_i_err, o_mem_we, o_busy;
    logic [31:0] o_d_rdata, o_i_rdata;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit act;
        bit rv;
        act = (m_phase == 1 || m_phase == 2);
        rv  = (m_phase == 3);
        chk1("busy", busy, m_phase != 0);
        chk1("owner", owner, m_own);
        chk1("mem_req", mem_req, act);
        chk1("mem_we", mem_we, act && m_we);
        chk32("mem_addr", mem_addr, act ? m_addr : 32'd0);
        chk32("mem_wdata", mem_wdata, act ? m_wdata : 32'd0);
        chk32("mem_byteen", {28'd0, mem_byteen}, act ? {28'd0, m_be} : 32'd0);
        chk1("d_gnt", d_gnt, m_phase == 1 && !m_own);
        chk1("i_gnt", i_gnt, m_phase == 1 && m_own);
        chk1("d_rvalid", d_rvalid, rv && !m_own);
        chk1("i_rvalid", i_rvalid, rv && m_own);
        chk32("d_rdata", d_rdata, (rv && !m_own) ? m_rdata : 32'd0);
        chk32("i_rdata", i_rdata, (rv && m_own) ? m_rdata : 32'd0);
        chk1("d_err", d_err, rv && !m_own && m_err);
        chk1("i_err", i_err, rv && m_own && m_err);
    endtask

    task automatic model_advance();
        bit win_i;
        if (rst) begin
            m_phase = 0; m_own = 1'b0; m_streak = 0;
            m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0; m_rdata = '0; m_err = 1'b0;
        end else if (m_phase == 0) begin
            if (d_req || i_req) begin
                if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
                    win_i = !m_own;
`else
                    win_i = (m_streak >= STARVE_MAX);
`endif
                end else begin
                    win_i = i_req;
                end
                m_own   = win_i;
                m_addr  = win_i ? i_addr : d_addr;
                m_wdata = win_i ? i_wdata : d_wdata;
                m_be    = win_i ? i_byteen : d_byteen;
                m_we    = win_i ? i_we : d_we;
                m_phase = 1;
                if (!i_req || win_i) m_streak = 0;
                else m_streak++;
            end else begin
                m_streak = 0;
            end
        end else if (m_phase == 2) begin
            m_rdata = m_we ? 32'd0 : mem_rdata;
            m_err   = mem_err;
            m_phase = 3;
        end else if (m_phase == 3) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end
    endtask

    task automatic new_d();
        d_req = 1'b1; d_addr = $urandom() & 32'hFFFF_FFFC; d_byteen = 4'($urandom_range(0, 15));
        d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom();
    endtask

    task automatic new_i();
        i_req = 1'b1; i_addr = $urandom() & 32'hFFFF_FFFC; i_byteen = 4'($urandom_range(0, 15));
        i_we = 1'($urandom_range(0, 1)); i_wdata = $urandom();
    endtask

    task automatic upd_reqs();
        if (m_rv_d) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) new_d();
            else d_req = 1'b0;
        end else if (mode == 2 && !d_req && $urandom_range(0, 2) == 0) begin
            new_d();
        end
        if (m_rv_i) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) new_i();
            else i_req = 1'b0;
        end else if (mode == 2 && !i_req && $urandom_range(0, 2) == 0) begin
            new_i();
        end
        if (mode == 1) begin
            d_we = 1'b0; i_we = 1'b0;
        end
        if (rand_mem) begin
            mem_rdata = $urandom();
            mem_err   = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        o_d_gnt = d_gnt; o_d_rvalid = d_rvalid; o_i_rvalid = i_rvalid;
        o_d_err = d_err; o_i_err = i_err; o_mem_we = mem_we; o_busy = busy;
        o_d_rdata = d_rdata; o_i_rdata = i_rdata;
        if (d_gnt) gnt_log.push_back(1'b0);
        if (i_gnt) gnt_log.push_back(1'b1);
        m_rv_d = (m_phase == 3) && !m_own;
        m_rv_i = (m_phase == 3) && m_own;
        model_advance();
        @(posedge clk);
        #1;
        upd_reqs();
    endtask

    initial begin
        int n;
        int nrv;
        // Reset: all outputs low.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Single D-side read at 0x100.
        d_req = 1'b1; d_addr = 32'h100; d_byteen = 4'hF; d_we = 1'b0; d_wdata = '0;
        mem_rdata = 32'hDEAD_BEEF; mem_err = 1'b0;
        tick();
        chk1("d_gnt_early", o_d_gnt, 1'b0);
        tick();
        chk1("d_gnt_t1", o_d_gnt, 1'b1);
        tick();
        chk1("d_rvalid_early", o_d_rvalid, 1'b0);
        tick();
        chk1("d_rvalid_t3", o_d_rvalid, 1'b1);
        chk32("d_rdata_t3", o_d_rdata, 32'hDEAD_BEEF);
        chk1("i_rvalid_t3", o_i_rvalid, 1'b0);
        repeat (2) tick();

        // I-side write.
        i_req = 1'b1; i_addr = 32'h200; i_byteen = 4'hF; i_we = 1'b1; i_wdata = 32'h1234_5678;
        mem_rdata = 32'hFFFF_FFFF;
        n = 0; nrv = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (o_mem_we) n++;
            if (o_i_rvalid) begin
                nrv++;
                chk32("i_write_rdata", o_i_rdata, 32'd0);
            end
        end
        chk32("mem_we_cycles", n, 32'd2);
        chk32("i_write_rvalids", nrv, 32'd1);

        // Both requesters held high: starvation guard order.
        gnt_log.delete();
        rand_mem = 1'b1;
        mode = 1;
        new_d(); new_i(); d_we = 1'b0; i_we = 1'b0;
        for (int k = 0; k < 80 && gnt_log.size() < 10; k++) tick();
        chk1("sat_grant_count", gnt_log.size() >= 10, 1'b1);
        for (int k = 0; k < 10 && k < gnt_log.size(); k++) begin
`ifdef MEM_ARB_RR_EN
            chk1($sformatf("sat_grant%0d", k), gnt_log[k], (k % 2) == 1);
`else
            chk1($sformatf("sat_grant%0d", k), gnt_log[k], (k % (STARVE_MAX + 1)) == STARVE_MAX);
`endif
        end
        mode = 0;
        repeat (14) tick();

        // mem_err on an I-side read.
        rand_mem = 1'b0;
        i_req = 1'b1; i_addr = 32'h40; i_byteen = 4'hF; i_we = 1'b0; i_wdata = '0;
        mem_rdata = 32'hCAFE_F00D; mem_err = 1'b1;
        nrv = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_i_rvalid) begin
                nrv++;
                chk1("i_err_with_rvalid", o_i_err, 1'b1);
                chk1("d_err_quiet", o_d_err, 1'b0);
            end
        end
        chk32("i_err_rvalids", nrv, 32'd1);
        mem_err = 1'b0;
        repeat (2) tick();

        // Reset during DATA, then the held request is served again.
        rand_mem = 1'b1;
        d_req = 1'b1; d_addr = 32'h300; d_byteen = 4'h3; d_we = 1'b0; d_wdata = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk1("post_rst_busy", o_busy, 1'b0);
        chk1("post_rst_rvalid", o_d_rvalid, 1'b0);
        nrv = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_d_rvalid) nrv++;
        end
        chk32("post_rst_served", nrv, 32'd1);

        // Randomized traffic with occasional reset.
        mode = 2;
        for (int k = 0; k < 600; k++) begin
            tick();
            rst = ($urandom_range(0, 59) == 0);
        end
        rst = 1'b0;
        mode = 0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
